// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants for the ID issue controller: immediate-type codes, opcodes, FSM states.
// Optional feature macro used by the top: ID_ISSUE_PERF_CNT_EN.
package id_issue_ctrl_pkg;

    localparam int INST_W_DEF = 32;
    localparam int XLEN_DEF   = 64;
    localparam int GEN_W_DEF  = 3;

    localparam logic [2:0] GEN_NONE          = 3'b000;
    localparam logic [2:0] GEN_CSR           = 3'b001;
    localparam logic [2:0] GEN_SHIFT         = 3'b010;
    localparam logic [2:0] GEN_STORE         = 3'b011;
    localparam logic [2:0] GEN_XUIX          = 3'b100;
    localparam logic [2:0] GEN_JAL           = 3'b101;
    localparam logic [2:0] GEN_JALR_LOAD_ALI = 3'b110;
    localparam logic [2:0] GEN_BRANCH        = 3'b111;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_LU_STALL = 2'd2
    } id_state_e;

endpackage

// File: rtl/id_issue_decode.sv
// Combinational opcode/funct3 decode into immediate-generator type and register usage.
module id_issue_decode
    import id_issue_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output logic [2:0] gen_type_o,
    output logic       rs1_used_o,
    output logic       rs2_used_o
);

    always_comb begin
        gen_type_o = GEN_NONE;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b0;
        case (opcode_i)
            OPC_STORE: begin
                gen_type_o = GEN_STORE;
                rs2_used_o = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                gen_type_o = GEN_XUIX;
                rs1_used_o = 1'b0;
            end
            OPC_JAL: begin
                gen_type_o = GEN_JAL;
                rs1_used_o = 1'b0;
            end
            OPC_JALR, OPC_LOAD: gen_type_o = GEN_JALR_LOAD_ALI;
            // funct3 001/101 are the shift-immediate forms (shamt, not a sign-extended imm)
            OPC_OP_IMM, OPC_OP_IMM_32:
                gen_type_o = (funct3_i[1:0] == 2'b01) ? GEN_SHIFT : GEN_JALR_LOAD_ALI;
            OPC_BRANCH: begin
                gen_type_o = GEN_BRANCH;
                rs2_used_o = 1'b1;
            end
            OPC_OP, OPC_OP_32: rs2_used_o = 1'b1;
            OPC_SYSTEM: begin
                if (funct3_i[2]) begin
                    gen_type_o = GEN_CSR;
                    rs1_used_o = 1'b0;
                end else if (funct3_i == 3'b000) begin
                    rs1_used_o = 1'b0;
                end
            end
            OPC_MISC_MEM: rs1_used_o = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage sequencer: IF/ID register, immediate-type decode, handshake and load-use bubble.
// Define ID_ISSUE_PERF_CNT_EN to build the load-use stall counter; otherwise stall_cnt_o is 0.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int INST_W = 32,
    parameter int GEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_id_valid_i,
    input  logic [INST_W-1:0] if_id_inst_i,
    input  logic [XLEN-1:0]   if_id_pc_i,
    output logic              id_ctrl_ready_o,
    input  logic              id_ctrl_flush_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_ready_i,
    output logic              id_ctrl_valid_o,
    output logic [INST_W-1:0] id_ctrl_inst_o,
    output logic [XLEN-1:0]   id_ctrl_pc_o,
    output logic [GEN_W-1:0]  id_ctrl_gen_type_o,
    output logic [4:0]        id_ctrl_rs1_o,
    output logic [4:0]        id_ctrl_rs2_o,
    output logic [XLEN-1:0]   id_ctrl_stall_cnt_o
);

    id_state_e         state_q, state_d;
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   pc_q;
    logic [GEN_W-1:0]  gen_q;
    logic [4:0]        rs1_q, rs2_q;
    logic [2:0]        dec_gen;
    logic              dec_rs1_used, dec_rs2_used;
    logic              hz, capture;

    id_issue_decode u_decode (
        .opcode_i   (if_id_inst_i[6:0]),
        .funct3_i   (if_id_inst_i[14:12]),
        .gen_type_o (dec_gen),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used)
    );

    // Unused source fields are zeroed at capture, so they can never match ex_rd_i here.
    assign hz = (state_q == ST_FULL) & ex_is_load_i & (ex_rd_i != 5'd0)
              & ((ex_rd_i == rs1_q) | (ex_rd_i == rs2_q));

    always_comb begin
        state_d         = state_q;
        id_ctrl_ready_o = 1'b0;
        id_ctrl_valid_o = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                id_ctrl_ready_o = 1'b1;
                if (if_id_valid_i) state_d = ST_FULL;
            end
            ST_FULL: begin
                id_ctrl_valid_o = ~hz;
                id_ctrl_ready_o = ex_ready_i & ~hz;
                if (hz & ex_ready_i)  state_d = ST_LU_STALL;
                else if (ex_ready_i)  state_d = if_id_valid_i ? ST_FULL : ST_EMPTY;
            end
            ST_LU_STALL: state_d = ST_FULL;
            default:     state_d = ST_EMPTY;
        endcase
        if (id_ctrl_flush_i) begin
            state_d         = ST_EMPTY;
            id_ctrl_ready_o = 1'b0;
        end
    end

    assign capture = if_id_valid_i & id_ctrl_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            inst_q  <= '0;
            pc_q    <= '0;
            gen_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                inst_q <= if_id_inst_i;
                pc_q   <= if_id_pc_i;
                gen_q  <= dec_gen;
                rs1_q  <= dec_rs1_used ? if_id_inst_i[19:15] : 5'd0;
                rs2_q  <= dec_rs2_used ? if_id_inst_i[24:20] : 5'd0;
            end
        end
    end

`ifdef ID_ISSUE_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q;
    logic            stall_enter;

    assign stall_enter = hz & ex_ready_i & ~id_ctrl_flush_i;

    always_ff @(posedge clk) begin
        if (rst)              stall_cnt_q <= '0;
        else if (stall_enter) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign id_ctrl_stall_cnt_o = stall_cnt_q;
`else
    assign id_ctrl_stall_cnt_o = '0;
`endif

    assign id_ctrl_inst_o     = inst_q;
    assign id_ctrl_pc_o       = pc_q;
    assign id_ctrl_gen_type_o = gen_q;
    assign id_ctrl_rs1_o      = rs1_q;
    assign id_ctrl_rs2_o      = rs2_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: expected issues queued at capture, checked when EX takes them.
module tb_id_issue_ctrl;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;
    localparam int GEN_W  = 3;

`ifdef ID_ISSUE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_SLLI  = 32'h03F09093;
    localparam logic [31:0] I_CSRWI = 32'h3002D073;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_id_valid = 1'b0;
    logic [INST_W-1:0] if_id_inst = '0;
    logic [XLEN-1:0]   if_id_pc = '0;
    logic              ready;
    logic              flush = 1'b0;
    logic              ex_is_load = 1'b0;
    logic [4:0]        ex_rd = '0;
    logic              ex_ready = 1'b1;
    logic              valid;
    logic [INST_W-1:0] inst_o;
    logic [XLEN-1:0]   pc_o;
    logic [GEN_W-1:0]  gen_o;
    logic [4:0]        rs1_o, rs2_o;
    logic [XLEN-1:0]   cnt_o;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [2:0]  gen;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    id_issue_ctrl #(.XLEN(XLEN), .INST_W(INST_W), .GEN_W(GEN_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_id_valid_i       (if_id_valid),
        .if_id_inst_i        (if_id_inst),
        .if_id_pc_i          (if_id_pc),
        .id_ctrl_ready_o     (ready),
        .id_ctrl_flush_i     (flush),
        .ex_is_load_i        (ex_is_load),
        .ex_rd_i             (ex_rd),
        .ex_ready_i          (ex_ready),
        .id_ctrl_valid_o     (valid),
        .id_ctrl_inst_o      (inst_o),
        .id_ctrl_pc_o        (pc_o),
        .id_ctrl_gen_type_o  (gen_o),
        .id_ctrl_rs1_o       (rs1_o),
        .id_ctrl_rs2_o       (rs2_o),
        .id_ctrl_stall_cnt_o (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, queue its expected decode.
    task automatic issue(input logic [31:0] inst, input logic [63:0] pc,
                         input logic [2:0] gen, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        int   n;
        if_id_valid = 1'b1;
        if_id_inst  = inst;
        if_id_pc    = pc;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) chk("issue_timeout", 64'd0, 64'd1);
        else begin
            e.inst = inst; e.pc = pc; e.gen = gen; e.rs1 = rs1; e.rs2 = rs2;
            sb.push_back(e);
        end
        step();
        if_id_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
        chk({tag, "_inst"},  {32'd0, inst_o}, 64'd0);
        chk({tag, "_pc"},    pc_o, 64'd0);
        chk({tag, "_gen"},   {61'd0, gen_o}, 64'd0);
        chk({tag, "_rs1"},   {59'd0, rs1_o}, 64'd0);
        chk({tag, "_rs2"},   {59'd0, rs2_o}, 64'd0);
        chk({tag, "_cnt"},   cnt_o, 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && valid && ex_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_issue", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("sb_inst", {32'd0, inst_o}, {32'd0, e.inst});
                chk("sb_pc",   pc_o, e.pc);
                chk("sb_gen",  {61'd0, gen_o}, {61'd0, e.gen});
                chk("sb_rs1",  {59'd0, rs1_o}, {59'd0, e.rs1});
                chk("sb_rs2",  {59'd0, rs2_o}, {59'd0, e.rs2});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) step();
        @(negedge clk);
        chk_zero_outputs("reset");
        step();
        rst = 1'b0;

        // back-to-back stream
        issue(I_ADDI, 64'h1000, 3'b110, 5'd0, 5'd0);
        issue(I_SW,   64'h1004, 3'b011, 5'd2, 5'd1);
        @(negedge clk); chk("p1_valid_sw", {63'd0, valid}, 64'd1);
        step();
        @(negedge clk); chk("p1_drained", {63'd0, valid}, 64'd0);
        step();

        // load-use on rs1: one bubble
        ex_is_load = 1'b1; ex_rd = 5'd1;
        issue(I_ADD, 64'h1008, 3'b000, 5'd1, 5'd2);
        @(negedge clk);
        chk("p2_hz_valid", {63'd0, valid}, 64'd0);
        chk("p2_hz_ready", {63'd0, ready}, 64'd0);
        step();
        ex_is_load = 1'b0;
        @(negedge clk);
        chk("p2_lu_valid", {63'd0, valid}, 64'd0);
        chk("p2_lu_ready", {63'd0, ready}, 64'd0);
        step();
        @(negedge clk);
        chk("p2_re_valid", {63'd0, valid}, 64'd1);
        chk("p2_cnt", cnt_o, PERF ? 64'd1 : 64'd0);
        step();

        // load with rd matching lui's raw rs1 field: rs1 unused, no stall
        ex_is_load = 1'b1; ex_rd = 5'd8;
        issue(I_LUI, 64'h100C, 3'b100, 5'd0, 5'd0);
        @(negedge clk);
        chk("p3_valid", {63'd0, valid}, 64'd1);
        chk("p3_ready", {63'd0, ready}, 64'd1);
        step();
        ex_is_load = 1'b0; ex_rd = 5'd0;

        // EX backpressure holds outputs, blocks capture
        issue(I_JAL, 64'h1010, 3'b101, 5'd0, 5'd0);
        ex_ready = 1'b0;
        if_id_valid = 1'b1; if_id_inst = I_SLLI; if_id_pc = 64'h1014;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p4_ready", {63'd0, ready}, 64'd0);
            chk("p4_valid", {63'd0, valid}, 64'd1);
            chk("p4_inst",  {32'd0, inst_o}, {32'd0, I_JAL});
            chk("p4_pc",    pc_o, 64'h1010);
            step();
        end
        ex_ready = 1'b1;
        issue(I_SLLI,  64'h1014, 3'b010, 5'd1, 5'd0);
        issue(I_CSRWI, 64'h1018, 3'b001, 5'd0, 5'd0);
        @(negedge clk); chk("p4_valid_csr", {63'd0, valid}, 64'd1);
        step();

        // flush during LU_STALL with an instruction on offer
        ex_is_load = 1'b1; ex_rd = 5'd2;
        issue(I_ADD, 64'h1020, 3'b000, 5'd1, 5'd2);
        @(negedge clk); chk("p5_hz_valid", {63'd0, valid}, 64'd0);
        step();
        ex_is_load = 1'b0; flush = 1'b1;
        if_id_valid = 1'b1; if_id_inst = I_SW; if_id_pc = 64'h1024;
        @(negedge clk);
        chk("p5_flush_ready", {63'd0, ready}, 64'd0);
        chk("p5_flush_valid", {63'd0, valid}, 64'd0);
        step();
        flush = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        chk("p5_empty_valid", {63'd0, valid}, 64'd0);
        chk("p5_no_capture",  {32'd0, inst_o}, {32'd0, I_ADD});
        chk("p5_empty_ready", {63'd0, ready}, 64'd1);
        chk("p5_cnt", cnt_o, PERF ? 64'd2 : 64'd0);
        e.inst = I_SW; e.pc = 64'h1024; e.gen = 3'b011; e.rs1 = 5'd2; e.rs2 = 5'd1;
        sb.push_back(e);
        step();
        if_id_valid = 1'b0;
        @(negedge clk); chk("p5_sw_valid", {63'd0, valid}, 64'd1);
        step();

        // reset in the middle of a stall
        ex_is_load = 1'b1; ex_rd = 5'd1;
        issue(I_ADD, 64'h1030, 3'b000, 5'd1, 5'd2);
        step();
        rst = 1'b1; ex_is_load = 1'b0;
        step();
        @(negedge clk);
        chk_zero_outputs("p6_rst");
        if (sb.size() > 0) void'(sb.pop_back());
        step();
        rst = 1'b0;
        issue(I_ADDI, 64'h2000, 3'b110, 5'd0, 5'd0);
        @(negedge clk); chk("p6_post_valid", {63'd0, valid}, 64'd1);
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- ID-stage sequencer for the pipelined RV64 core.
- Owns the IF/ID pipeline register and decodes the opcode into the 3-bit immediate-generator type code that configures the ID immediate generator.
- Runs the valid/ready handshake toward IF and EX and inserts load-use bubbles.
- Sits between the fetch stage and the ID immediate generator / register-file read.

Parameters:
- XLEN, 64, data/PC width.
- INST_W, 32, instruction width.
- GEN_W, 3, immediate-type code width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_id_valid_i  in  1  IF presents an instruction
- if_id_inst_i  in  INST_W  fetched instruction
- if_id_pc_i  in  XLEN  PC of fetched instruction
- id_ctrl_ready_o  out  1  ID accepts this cycle (combinational)
- id_ctrl_flush_i  in  1  redirect/flush from EX
- ex_is_load_i  in  1  EX stage holds a load
- ex_rd_i  in  5  EX stage destination register
- ex_ready_i  in  1  EX accepts this cycle
- id_ctrl_valid_o  out  1  ID presents an instruction to EX
- id_ctrl_inst_o  out  INST_W  registered instruction
- id_ctrl_pc_o  out  XLEN  registered PC
- id_ctrl_gen_type_o  out  GEN_W  registered immediate type for the immediate generator
- id_ctrl_rs1_o  out  5  rs1 field, 0 if unused
- id_ctrl_rs2_o  out  5  rs2 field, 0 if unused
- id_ctrl_stall_cnt_o  out  XLEN  load-use stall cycle count

Behaviour:
- Clocking: single clock clk; rst synchronous, active-high.
- Reset values: state EMPTY; valid_o 0; inst_o, pc_o, gen_type_o, rs1_o, rs2_o, stall_cnt_o all 0.

Decode (at capture, registered with the instruction), gen_type:
- 011: store (0100011).
- 100: LUI/AUIPC.
- 101: JAL.
- 110: JALR, LOAD, OP-IMM and OP-IMM-32 except shifts.
- 111: BRANCH.
- 010: OP-IMM/OP-IMM-32 with funct3 001/101.
- 001: SYSTEM with funct3[2]=1 (CSR-immediate forms).
- 000: everything else.

Register usage:
- rs1 used except for LUI, AUIPC, JAL, CSR-immediate and 000-class non-register ops (ecall, ebreak, fence).
- rs2 used for store, branch, OP (0110011) and OP-32 (0111011).
- Unused fields are output as 0.

Hazard:
- hz = valid_q & ex_is_load_i & (ex_rd_i != 0) & ((ex_rd_i == rs1_o) | (ex_rd_i == rs2_o)).
- Forwarding covers MEM->EX, so one bubble always suffices.

FSM states:
- EMPTY: valid_o=0. Ready=1 unless flush. Capture on if_id_valid_i -> FULL.
- FULL: valid_o = ~hz.
  - If hz & ex_ready_i -> LU_STALL, stall_cnt++.
  - Else if ex_ready_i: if if_id_valid_i, capture the next instruction (stay FULL); otherwise -> EMPTY.
  - Else hold all registers.
- LU_STALL: valid_o=0, ready=0, exactly one cycle, then -> FULL with the same instruction.

Ready and flush:
- id_ctrl_ready_o = ~flush & (EMPTY | (FULL & ex_ready_i & ~hz)).
- Flush has priority over every state, stall and capture: next state EMPTY, valid_q cleared, if_id input not accepted that cycle.

Latency and ordering:
- Capture at edge N -> outputs valid after edge N.
- Back-to-back throughput is 1/cycle with no hazard.
- Output registers are stable while valid_o=1 and ex_ready_i=0.

Other rules:
- rst mid-stall returns to EMPTY.
- stall_cnt_o wraps modulo 2^XLEN.

Optional Feature:
- Macro: ID_ISSUE_PERF_CNT_EN.
- Defined: stall_cnt_o counts LU_STALL entry cycles.
- Undefined: counter logic omitted, stall_cnt_o tied to 0.
- The port exists in both builds.

Decomposition:
- Shared defines header holds:
  - GEN_TYPE codes: GEN_NONE=000, GEN_CSR=001, GEN_SHIFT=010, GEN_STORE=011, GEN_XUIX=100, GEN_JAL=101, GEN_JALR_LOAD_ALI=110, GEN_BRANCH=111.
  - Opcode constants.
  - INST/DATA bus widths.
  - FSM state encodings.
- One natural sub-module: id_issue_decode. It is purely combinational: opcode/funct3 -> gen_type, rs1_used, rs2_used. It is instantiated once, on the capture path.

Test Plan:
- Reset then stream addi x1,x0,5 (0x00500093), sw x1,0(x2) with ex_ready_i=1 -> valid_o one cycle after each capture; gen_type 110 then 011; rs2_o 0 then 1.
- In FULL holding add x3,x1,x2 with ex_is_load_i=1, ex_rd_i=1 -> valid_o=0 and ready=0 for 2 cycles (FULL-hz, LU_STALL); re-presented in cycle 3; stall_cnt_o=1 with the macro, 0 without.
- ex_rd_i=0 with ex_is_load_i=1 and lui x5 -> no stall; gen_type 100, rs1_o=0.
- ex_ready_i=0 for 4 cycles with if_id_valid_i=1 -> ready_o=0; inst_o/pc_o unchanged; no capture.
- id_ctrl_flush_i=1 during LU_STALL while if_id_valid_i=1 -> next cycle EMPTY, valid_o=0, offered instruction not captured; following cycle captures normally.
- slli x1,x1,63 (0x03F09093) -> gen_type 010; csrrwi x0,mstatus,5 -> gen_type 001; rst asserted mid-stream -> all outputs 0 next cycle.
